// File: rtl/vlc_frame_parser.sv
// VLC receive frame parser: sync hunt, header/length check, payload FIFO with
// valid/ready, trailing XOR checksum and idle timeout, with per-frame status.
module vlc_frame_parser #(
  parameter logic [31:0] SYNC_WORD  = 32'hA5C3_5A3C,
  parameter logic [15:0] MAX_LEN    = 16'd256,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic [31:0] iWord,
  input  logic        iWrite,
  output logic [31:0] oData,
  output logic        oLast,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oFrameId,
  output logic [15:0] oLen,
  output logic        oFrameDone,
  output logic [2:0]  oErrCode,
  output logic        oOverflow
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned ENTRY_W = 33;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_LEN      = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  typedef enum logic [1:0] {
    S_HUNT,
    S_HEADER,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t              state;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_nxt;
  logic [15:0]         cnt;
  logic [31:0]         acc;
  logic                frame_drop;
  logic [IDLE_W-1:0]   idle;

  logic pop;
  logic push_req;
  logic push_ok;
  logic last_word;
  logic bad_len;
  logic idle_expire;

  // Show-ahead head of the payload FIFO.
  assign oData = mem[rd_ptr][31:0];
  assign oLast = mem[rd_ptr][32];

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  always_comb begin
    pop         = oValid & iReady;
    push_req    = (state == S_PAYLOAD) && iWrite;
    push_ok     = push_req && ((count < CNT_W'(FIFO_DEPTH)) || pop);
    last_word   = (cnt == (oLen - 16'd1));
    bad_len     = (iWord[15:0] == 16'd0) || (iWord[15:0] > MAX_LEN);
    idle_expire = (state != S_HUNT) && !iWrite && (idle == IDLE_W'(TIMEOUT - 1));
    count_nxt   = count + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state      <= S_HUNT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      oValid     <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      frame_drop <= 1'b0;
      idle       <= '0;
      oFrameId   <= '0;
      oLen       <= '0;
      oFrameDone <= 1'b0;
      oErrCode   <= ERR_OK;
      oOverflow  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      oFrameDone <= 1'b0;

      // Payload FIFO bookkeeping.
      if (push_ok) begin
        mem[wr_ptr] <= {last_word, iWord};
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count  <= count_nxt;
      oValid <= (count_nxt != '0);

      // Idle counter only matters while a frame is open.
      if (iWrite) begin
        idle <= '0;
      end else if (state != S_HUNT) begin
        idle <= idle + IDLE_W'(1);
      end

      case (state)
        S_HUNT: begin
          if (iWrite && (iWord == SYNC_WORD)) begin
            state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (iWrite) begin
            oFrameId   <= iWord[31:16];
            oLen       <= iWord[15:0];
            acc        <= iWord;
            cnt        <= '0;
            frame_drop <= 1'b0;
            if (bad_len) begin
              oFrameDone <= 1'b1;
              oErrCode   <= ERR_LEN;
              state      <= S_HUNT;
            end else begin
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (iWrite) begin
            acc <= acc ^ iWord;
            cnt <= cnt + 16'd1;
            // Dropped words still advance cnt/acc so the frame boundary is kept.
            if (!push_ok) begin
              oOverflow  <= 1'b1;
              frame_drop <= 1'b1;
            end
            if (last_word) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (iWrite) begin
            oFrameDone <= 1'b1;
            if (frame_drop) begin
              oErrCode <= ERR_OVERFLOW;
            end else if (iWord != acc) begin
              oErrCode <= ERR_CHECKSUM;
            end else begin
              oErrCode <= ERR_OK;
            end
            state <= S_HUNT;
          end
        end
        default: begin
          state <= S_HUNT;
        end
      endcase

      // Abort an open frame after too long without input; FIFO contents stay.
      if (idle_expire) begin
        oFrameDone <= 1'b1;
        oErrCode   <= ERR_TIMEOUT;
        state      <= S_HUNT;
        idle       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vlc_frame_parser.sv
// Bench for vlc_frame_parser: random frames against a queue-based frame model,
// plus bad length, overflow, timeout, full-FIFO pop+push and mid-frame reset.
module tb_vlc_frame_parser;

  localparam logic [31:0] SYNC    = 32'hA5C3_5A3C;
  localparam int          MAXLEN  = 256;
  localparam int          DEPTH   = 16;
  localparam int          TMO     = 1024;
  localparam int          BUDGET  = 3000;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic [31:0] iWord;
  logic        iWrite;
  logic [31:0] oData;
  logic        oLast;
  logic        oValid;
  logic        iReady;
  logic [15:0] oFrameId;
  logic [15:0] oLen;
  logic        oFrameDone;
  logic [2:0]  oErrCode;
  logic        oOverflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_wr_cyc = 0;

  logic [32:0] out_q [$];
  logic [32:0] exp_q [$];
  logic [2:0]  code_q [$];
  logic [15:0] id_q [$];
  logic [15:0] len_q [$];
  int          done_cyc_q [$];
  logic [31:0] pl_q [$];
  logic [2:0]  exp_code;

  vlc_frame_parser dut (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iWord      (iWord),
    .iWrite     (iWrite),
    .oData      (oData),
    .oLast      (oLast),
    .oValid     (oValid),
    .iReady     (iReady),
    .oFrameId   (oFrameId),
    .oLen       (oLen),
    .oFrameDone (oFrameDone),
    .oErrCode   (oErrCode),
    .oOverflow  (oOverflow)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Observe consumed words and status pulses mid-cycle.
  always @(negedge iClk) begin
    if (iReset_n) begin
      if (oValid && iReady) out_q.push_back({oLast, oData});
      if (oFrameDone) begin
        code_q.push_back(oErrCode);
        id_q.push_back(oFrameId);
        len_q.push_back(oLen);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic int rg(input int m);
    return (m == 0) ? 0 : int'($urandom_range(0, m));
  endfunction

  task automatic clear_obs();
    out_q.delete();
    code_q.delete();
    id_q.delete();
    len_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic do_reset();
    iReset_n = 1'b0;
    iWrite   = 1'b0;
    iWord    = '0;
    iReady   = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iReset_n = 1'b1;
    clear_obs();
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    iWord  = w;
    iWrite = 1'b1;
    @(posedge iClk);
    #1;
    last_wr_cyc = cyc;
    iWrite = 1'b0;
    iWord  = '0;
    repeat (gap) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic fill_random(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back($urandom);
  endtask

  // Send SYNC, header, payload from pl_q and checksum; build the expected results.
  task automatic send_frame(input logic [15:0] id, input logic [15:0] len, input bit corrupt,
                            input int maxgap, input int ready_at);
    logic [31:0] acc;
    int n;
    acc = {id, len};
    n = int'(len);
    exp_q.delete();
    send(SYNC, rg(maxgap));
    send({id, len}, rg(maxgap));
    if (n == 0 || n > MAXLEN) begin
      exp_code = 3'd1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i == ready_at) iReady = 1'b1;
      acc = acc ^ pl_q[i];
      exp_q.push_back({i == n - 1, pl_q[i]});
      send(pl_q[i], rg(maxgap));
    end
    send(corrupt ? (acc ^ 32'h0000_0100) : acc, 0);
    exp_code = corrupt ? 3'd2 : 3'd0;
  endtask

  task automatic wait_events(input int nd, input int no, input int budget, input string name);
    int t = 0;
    while ((code_q.size() < nd || out_q.size() < no) && t < budget) begin
      @(posedge iClk);
      #1;
      t++;
    end
    repeat (3) begin
      @(posedge iClk);
      #1;
    end
    if (t >= budget) begin
      checks++; failures++;
      $display("FAIL %s_wait: done=%0d out=%0d, required done=%0d out=%0d", name,
               code_q.size(), out_q.size(), nd, no);
    end
  endtask

  task automatic check_frame(input string name, input logic [2:0] ec,
                             input logic [15:0] eid, input logic [15:0] elen);
    int n;
    wait_events(1, exp_q.size(), BUDGET, name);
    checks++;
    if (code_q.size() !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d want 1", name, code_q.size());
    end
    if (code_q.size() >= 1) begin
      checks++;
      if (code_q[0] !== ec) begin
        failures++;
        $display("FAIL %s_code: got %0d want %0d", name, code_q[0], ec);
      end
      checks++;
      if (id_q[0] !== eid || len_q[0] !== elen) begin
        failures++;
        $display("FAIL %s_id_len: got %h/%0d want %h/%0d", name, id_q[0], len_q[0], eid, elen);
      end
    end
    checks++;
    if (out_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_out_count: got %0d want %0d", name, out_q.size(), exp_q.size());
    end
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_word%0d: got %h want %h", name, i, out_q[i], exp_q[i]);
      end
    end
    clear_obs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({oValid, oFrameDone, oOverflow, oErrCode, oFrameId, oLen, oData, oLast} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%b o=%b e=%0d id=%h len=%h data=%h last=%b want all 0",
               oValid, oFrameDone, oOverflow, oErrCode, oFrameId, oLen, oData, oLast);
    end
  endtask

  task automatic test_good_frame();
    logic [15:0] id, len;
    do_reset();
    pl_q = '{32'd1, 32'd2, 32'd3};
    send_frame(16'h0007, 16'd3, 1'b0, 0, -1);
    checks++;
    if (exp_code !== 3'd0 || exp_q.size() != 3) begin
      failures++;
      $display("FAIL model_frame1: got code %0d size %0d want 0/3", exp_code, exp_q.size());
    end
    check_frame("frame1", 3'd0, 16'h0007, 16'd3);
    for (int f = 0; f < 4; f++) begin
      id  = 16'($urandom);
      len = 16'($urandom_range(1, 40));
      fill_random(int'(len));
      send_frame(id, len, 1'($urandom_range(0, 1)), 2, -1);
      check_frame("rand_frame", exp_code, id, len);
    end
    fill_random(MAXLEN);
    send_frame(16'h00AB, 16'(MAXLEN), 1'b0, 0, -1);
    check_frame("max_len", 3'd0, 16'h00AB, 16'(MAXLEN));
  endtask

  task automatic test_bad_checksum();
    do_reset();
    pl_q = '{32'd1, 32'd2, 32'd3};
    acc_zero_frame();
    check_frame("bad_chk", 3'd2, 16'h0007, 16'd3);
  endtask

  // Frame with a literal all-zero checksum word.
  task automatic acc_zero_frame();
    exp_q.delete();
    send(SYNC, 0);
    send(32'h0007_0003, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({i == 2, pl_q[i]});
      send(pl_q[i], 0);
    end
    send(32'h0, 0);
  endtask

  task automatic test_bad_len();
    do_reset();
    send_frame(16'h0011, 16'd0, 1'b0, 1, -1);
    check_frame("len_zero", 3'd1, 16'h0011, 16'd0);
    send_frame(16'h0022, 16'(MAXLEN + 1), 1'b0, 1, -1);
    check_frame("len_over", 3'd1, 16'h0022, 16'(MAXLEN + 1));
    fill_random(5);
    send_frame(16'h0033, 16'd5, 1'b0, 1, -1);
    check_frame("after_badlen", 3'd0, 16'h0033, 16'd5);
  endtask

  task automatic test_overflow();
    do_reset();
    iReady = 1'b0;
    fill_random(20);
    send_frame(16'h0044, 16'd20, 1'b0, 0, -1);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    wait_events(1, 0, 100, "ovf");
    checks++;
    if (code_q.size() < 1 || code_q[0] !== 3'd3) begin
      failures++;
      $display("FAIL ovf_code: got %0d entries first %0d want code 3", code_q.size(),
               (code_q.size() > 0) ? code_q[0] : 3'd7);
    end
    checks++;
    if (oOverflow !== 1'b1 || oValid !== 1'b1 || out_q.size() != 0) begin
      failures++;
      $display("FAIL ovf_flags: got ovf=%b valid=%b out=%0d want 1/1/0", oOverflow, oValid,
               out_q.size());
    end
    code_q.delete(); id_q.delete(); len_q.delete();
    iReady = 1'b1;
    wait_events(0, DEPTH, 100, "ovf_drain");
    checks++;
    if (out_q.size() != DEPTH || oValid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain_count: got %0d valid=%b want %0d valid=0", out_q.size(), oValid, DEPTH);
    end
    for (int i = 0; i < DEPTH && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
    checks++;
    if (oErrCode !== 3'd3 || oOverflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold: got code %0d ovf %b want 3/1", oErrCode, oOverflow);
    end
    clear_obs();
  endtask

  task automatic test_timeout();
    do_reset();
    exp_q.delete();
    pl_q = '{32'hDEAD_0001, 32'hDEAD_0002};
    send(SYNC, 0);
    send(32'h0055_0005, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, pl_q[i]});
      send(pl_q[i], 0);
    end
    wait_events(1, 2, TMO + 100, "timeout");
    checks++;
    if (code_q.size() != 1 || code_q[0] !== 3'd4) begin
      failures++;
      $display("FAIL timeout_code: got %0d entries first %0d want one code 4", code_q.size(),
               (code_q.size() > 0) ? code_q[0] : 3'd7);
    end
    if (done_cyc_q.size() > 0) begin
      checks++;
      if (done_cyc_q[0] - last_wr_cyc != TMO) begin
        failures++;
        $display("FAIL timeout_delay: got %0d want %0d", done_cyc_q[0] - last_wr_cyc, TMO);
      end
    end
    for (int i = 0; i < 2 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL timeout_word%0d: got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
    clear_obs();
    fill_random(4);
    send_frame(16'h0066, 16'd4, 1'b0, 1, -1);
    check_frame("after_timeout", 3'd0, 16'h0066, 16'd4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(32'h0, 0);
    send(32'h1234_5678, 0);
    send(32'h0, 3);
    checks++;
    if (code_q.size() != 0 || out_q.size() != 0 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL hunt_ignore: got done=%0d out=%0d valid=%b want 0/0/0", code_q.size(),
               out_q.size(), oValid);
    end
    // Fill the FIFO, then push and pop together on the last two words.
    iReady = 1'b0;
    fill_random(18);
    send_frame(16'h0077, 16'd18, 1'b0, 0, DEPTH);
    check_frame("full_pop_push", 3'd0, 16'h0077, 16'd18);
    checks++;
    if (oOverflow !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_push_ovf: got %b want 0", oOverflow);
    end
    // Reset while payload is arriving.
    iReady = 1'b0;
    send(SYNC, 0);
    send(32'h0088_000A, 0);
    send(32'h1111_1111, 0);
    send(32'h2222_2222, 0);
    send(32'h3333_3333, 1);
    checks++;
    if (oValid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_valid: got %b want 1", oValid);
    end
    iReset_n = 1'b0;
    @(posedge iClk);
    #1;
    checks++;
    if (oValid !== 1'b0 || oFrameDone !== 1'b0 || oFrameId !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b done=%b id=%h want 0/0/0", oValid, oFrameDone, oFrameId);
    end
    iReset_n = 1'b1;
    iReady = 1'b1;
    clear_obs();
    fill_random(6);
    send_frame(16'h0099, 16'd6, 1'b0, 1, -1);
    check_frame("after_reset", 3'd0, 16'h0099, 16'd6);
  endtask

  initial begin
    iReset_n = 1'b0;
    iWrite   = 1'b0;
    iWord    = '0;
    iReady   = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_len();
    test_overflow();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
